// File: rtl/hex_display_ctrl_pkg.sv
// Shared types and glyph helpers for the multi-digit 7-segment display controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } disp_state_t;

  // Active-low {g..a} glyph for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Value-input handshake bundle for hex_display_ctrl.
interface hex_display_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*NUM_DIGITS-1:0] in_value;
  logic                    in_dec;
  logic                    in_blank_lz;

  modport master (output in_valid, output in_value, output in_dec, output in_blank_lz,
                  input  in_ready);
  modport slave  (input  in_valid, input  in_value, input  in_dec, input  in_blank_lz,
                  output in_ready);
endinterface

// File: rtl/hex_display_ctrl_bin_to_bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle after start, BIN_W steps total.
module bin_to_bcd #(
  parameter int BIN_W      = 24,
  parameter int BCD_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r;
  logic [BCD_W-1:0] adj_s;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;

  // Add 3 to every BCD digit >= 5 ahead of the shift
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  // Conversion state: load on start, then one shift per cycle while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r  <= '0;
      bcd_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      bin_r  <= bin;
      bcd_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      bcd_r <= BCD_W'({adj_s, bin_r[BIN_W-1]});
      bin_r <= bin_r << 1;
      if (cnt_r == LAST) begin
        busy_r <= 1'b0;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // done is high in the cycle whose closing edge performs the final step
  assign done = busy_r && (cnt_r == LAST);
  assign bcd  = bcd_r;

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low 7-segment controller: hex/decimal display, blanking, overflow, blink.
module hex_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  hex_display_ctrl_if.slave       in_if,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blink_en,
  output logic                    ovf,
  output logic [7*NUM_DIGITS-1:0] seg_n,
  output logic [NUM_DIGITS-1:0]   dp_n
);

  localparam int W          = 4 * NUM_DIGITS;
  localparam int BCD_DIGITS = NUM_DIGITS + 2;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int HALF_RAW   = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF       = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CNT_W      = (HALF > 1) ? $clog2(HALF) : 1;

  disp_state_t             state_r, state_nx_s;
  logic                    in_ready_s, accept_s, start_s, commit_s;
  logic [W-1:0]            digit_r;
  logic                    blank_lz_r, blz_pend_r, ovf_r;
  logic                    conv_done_s;
  logic [BCD_W-1:0]        bcd_s;
  logic [7*NUM_DIGITS-1:0] glyph_s;
  logic                    seen_s;
  logic [3:0]              nib_s;
  logic [CNT_W-1:0]        blink_cnt_r;
  logic                    phase_on_r, blink_off_s;
  logic [7*NUM_DIGITS-1:0] seg_n_r;
  logic [NUM_DIGITS-1:0]   dp_n_r;

  bin_to_bcd #(.BIN_W(W), .BCD_DIGITS(BCD_DIGITS)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .bin   (in_if.in_value),
    .done  (conv_done_s),
    .bcd   (bcd_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // FSM next-state logic; hex loads never leave IDLE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (in_if.in_valid && in_if.in_dec) state_nx_s = CONV;   else state_nx_s = IDLE;
      CONV:    if (conv_done_s)                    state_nx_s = COMMIT; else state_nx_s = CONV;
      COMMIT:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    in_ready_s = 1'b0;
    start_s    = 1'b0;
    commit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        start_s    = in_if.in_valid && in_if.in_dec;
      end
      CONV:    in_ready_s = 1'b0;
      COMMIT:  commit_s   = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign in_if.in_ready = in_ready_s;
  assign accept_s       = in_if.in_valid && in_ready_s;

  // Digit register; decimal blanking choice waits in blz_pend_r until commit
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_r    <= '0;
      blank_lz_r <= 1'b0;
      blz_pend_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (accept_s && !in_if.in_dec) begin
      digit_r    <= in_if.in_value;
      blank_lz_r <= in_if.in_blank_lz;
      ovf_r      <= 1'b0;
    end else if (start_s) begin
      blz_pend_r <= in_if.in_blank_lz;
    end else if (commit_s) begin
      digit_r    <= bcd_s[W-1:0];
      blank_lz_r <= blz_pend_r;
      ovf_r      <= |bcd_s[BCD_W-1:W];
    end
  end

  // Glyph selection, scanning from the top digit to find the leading nonzero
  always_comb begin
    glyph_s = '1;
    seen_s  = 1'b0;
    nib_s   = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib_s = digit_r[4*i +: 4];
      if (ovf_r) begin
        glyph_s[7*i +: 7] = SEG_DASH;
      end else if (blank_lz_r && !seen_s && (nib_s == 4'd0) && (i != 0)) begin
        glyph_s[7*i +: 7] = SEG_BLANK;
      end else begin
        glyph_s[7*i +: 7] = hex_to_seg(nib_s);
      end
      if (nib_s != 4'd0) seen_s = 1'b1;
      else               seen_s = seen_s;
    end
  end

  // Blink half-period counter and on/off phase
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt_r <= '0;
      phase_on_r  <= 1'b1;
    end else if (blink_cnt_r == CNT_W'(HALF - 1)) begin
      blink_cnt_r <= '0;
      phase_on_r  <= ~phase_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + CNT_W'(1);
    end
  end

  // Gating on blink_en directly lets the display return the edge after blink is dropped
  assign blink_off_s = blink_en && !phase_on_r;

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (rst || blink_off_s) begin
      seg_n_r <= '1;
      dp_n_r  <= '1;
    end else begin
      seg_n_r <= glyph_s;
      dp_n_r  <= ~dp_in;
    end
  end

  assign seg_n = seg_n_r;
  assign dp_n  = dp_n_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl against a decimal/hex arithmetic reference model.
module tb_hex_display_ctrl;

  localparam int ND        = 6;
  localparam int EXP_BUSY  = 4 * ND + 1;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic            clk = 1'b0;
  logic            rst;
  logic [ND-1:0]   dp_in;
  logic            blink_en;
  logic            ovf;
  logic [7*ND-1:0] seg_n;
  logic [ND-1:0]   dp_n;
  int              n_cmp = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  hex_display_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  hex_display_ctrl #(.NUM_DIGITS(ND), .CLK_HZ(8), .BLINK_HZ(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_if    (bus),
    .dp_in    (dp_in),
    .blink_en (blink_en),
    .ovf      (ovf),
    .seg_n    (seg_n),
    .dp_n     (dp_n)
  );

  // Reference: what a human reads on the display for a given value and mode
  function automatic void model(input logic [23:0] v, input bit dec, input bit blz,
                                output logic [7*ND-1:0] seg, output bit ov);
    int unsigned x;
    int dig [ND];
    int msd;
    x  = v;
    ov = dec && (x > 999999);
    for (int i = 0; i < ND; i++) begin
      if (dec) begin
        dig[i] = int'(x % 10);
        x      = x / 10;
      end else begin
        dig[i] = int'((v >> (4 * i)) & 24'hF);
      end
    end
    msd = 0;
    for (int i = 0; i < ND; i++) if (dig[i] != 0) msd = i;
    for (int i = 0; i < ND; i++) begin
      if (ov)                 seg[7*i +: 7] = 7'h3F;
      else if (blz && i > msd) seg[7*i +: 7] = 7'h7F;
      else                    seg[7*i +: 7] = GLYPH[dig[i]];
    end
  endfunction

  task automatic send(input logic [23:0] v, input bit dec, input bit blz);
    bus.in_value    = v;
    bus.in_dec      = dec;
    bus.in_blank_lz = blz;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
  endtask

  task automatic wait_conv(output int busy);
    busy = 0;
    @(negedge clk);
    while (!bus.in_ready && busy < 200) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dp_in = '1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (seg_n !== '1)   begin n_err++; $display("FAIL reset_seg: got %h want all ones", seg_n); end
    n_cmp++; if (dp_n !== '1)    begin n_err++; $display("FAIL reset_dp: got %h want all ones", dp_n); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    dp_in = '0;
  endtask

  task automatic test_hex();
    logic [7*ND-1:0] exp_seg;
    logic [23:0] v;
    bit ov, blz;
    send(24'h12AB0F, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL hex_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    model(24'h12AB0F, 1'b0, 1'b0, exp_seg, ov);
    n_cmp++; if (seg_n !== exp_seg) begin n_err++; $display("FAIL hex_fixed: got %h want %h", seg_n, exp_seg); end
    for (int i = 0; i < 8; i++) begin
      v     = 24'($urandom);
      if (i % 3 == 0) v = v & 24'h000FFF;
      if (i == 4)     v = 24'h0;
      blz   = 1'($urandom % 2);
      dp_in = ND'($urandom);
      send(v, 1'b0, blz);
      @(posedge clk); #1;
      model(v, 1'b0, blz, exp_seg, ov);
      n_cmp++; if (seg_n !== exp_seg) begin n_err++; $display("FAIL hex_rand: v=%h blz=%0d got %h want %h", v, blz, seg_n, exp_seg); end
      n_cmp++; if (dp_n !== ~dp_in)   begin n_err++; $display("FAIL hex_dp: got %b want %b", dp_n, ~dp_in); end
      n_cmp++; if (ovf !== 1'b0)      begin n_err++; $display("FAIL hex_ovf: got %b want 0", ovf); end
    end
  endtask

  task automatic test_dec();
    logic [7*ND-1:0] exp_seg;
    logic [23:0] v;
    bit ov, blz;
    int busy;
    for (int i = 0; i < 7; i++) begin
      case (i % 3)
        0:       v = 24'($urandom_range(0, 999));
        1:       v = 24'($urandom_range(0, 999999));
        default: v = 24'($urandom_range(1000000, 16777215));
      endcase
      if (i == 0) v = 24'd4095;
      blz = (i == 0) ? 1'b1 : 1'($urandom % 2);
      send(v, 1'b1, blz);
      wait_conv(busy);
      n_cmp++; if (busy != EXP_BUSY) begin n_err++; $display("FAIL dec_busy: v=%0d got %0d cycles want %0d", v, busy, EXP_BUSY); end
      @(posedge clk); #1;
      model(v, 1'b1, blz, exp_seg, ov);
      n_cmp++; if (seg_n !== exp_seg) begin n_err++; $display("FAIL dec_seg: v=%0d blz=%0d got %h want %h", v, blz, seg_n, exp_seg); end
      n_cmp++; if (ovf !== ov)        begin n_err++; $display("FAIL dec_ovf: v=%0d got %b want %b", v, ovf, ov); end
    end
  endtask

  task automatic test_overflow();
    logic [7*ND-1:0] exp_seg;
    bit ov;
    int busy;
    send(24'd1000000, 1'b1, 1'b1);
    wait_conv(busy);
    @(posedge clk); #1;
    n_cmp++; if (ovf !== 1'b1)          begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
    n_cmp++; if (seg_n !== {ND{7'h3F}}) begin n_err++; $display("FAIL ovf_dash: got %h want %h", seg_n, {ND{7'h3F}}); end
    send(24'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    model(24'h0, 1'b0, 1'b0, exp_seg, ov);
    n_cmp++; if (ovf !== 1'b0)      begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    n_cmp++; if (seg_n !== exp_seg) begin n_err++; $display("FAIL ovf_zeros: got %h want %h", seg_n, exp_seg); end
  endtask

  task automatic test_ignore_during_conv();
    logic [7*ND-1:0] exp_seg;
    bit ov;
    int busy;
    send(24'd123456, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.in_value = 24'd7;
    bus.in_dec   = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_conv(busy);
    @(posedge clk); #1;
    model(24'd123456, 1'b1, 1'b1, exp_seg, ov);
    n_cmp++; if (seg_n !== exp_seg) begin n_err++; $display("FAIL ignore_seg: got %h want %h", seg_n, exp_seg); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ignore_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (seg_n !== exp_seg)     begin n_err++; $display("FAIL ignore_hold: got %h want %h", seg_n, exp_seg); end
  endtask

  task automatic test_reset_mid_conv();
    logic [7*ND-1:0] exp_seg;
    bit ov;
    send(24'd999, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (seg_n !== '1)          begin n_err++; $display("FAIL midrst_seg: got %h want all ones", seg_n); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    model(24'h0, 1'b0, 1'b0, exp_seg, ov);
    n_cmp++; if (seg_n !== exp_seg) begin n_err++; $display("FAIL midrst_abort: got %h want %h", seg_n, exp_seg); end
  endtask

  task automatic test_blink();
    logic [7*ND-1:0] exp_seg;
    bit ov, on;
    dp_in = 6'b000101;
    send(24'h00ABCD, 1'b0, 1'b1);
    @(posedge clk); #1;
    model(24'h00ABCD, 1'b0, 1'b1, exp_seg, ov);
    blink_en = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk); #1;
      on = ((j / 4) % 2) == 0;
      n_cmp++; if (seg_n !== (on ? exp_seg : {7*ND{1'b1}})) begin n_err++; $display("FAIL blink_seg: j=%0d got %h on=%0d", j, seg_n, on); end
      n_cmp++; if (dp_n !== (on ? ~dp_in : {ND{1'b1}}))     begin n_err++; $display("FAIL blink_dp: j=%0d got %b on=%0d", j, dp_n, on); end
    end
    blink_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      n_cmp++; if (seg_n !== exp_seg) begin n_err++; $display("FAIL blink_off: j=%0d got %h want %h", j, seg_n, exp_seg); end
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_value    = '0;
    bus.in_dec      = 1'b0;
    bus.in_blank_lz = 1'b0;
    blink_en        = 1'b0;
    rst             = 1'b1;
    dp_in           = '0;
    #1;
    test_reset();
    test_hex();
    test_dec();
    test_overflow();
    test_ignore_during_conv();
    test_reset_mid_conv();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
